manchester_rx_adaptive: RTL

Parametrised, rate-tracking Manchester receiver with word assembly and a valid/ready output. It synchronises and glitch-filters the line input, classifies pulse widths against a bit-length estimate that is continuously adapted, and decodes bits. It packs the decoded bits into WORD_W-bit words handed to the downstream consumer. It replaces the fixed-rate single-bit decoder in the LED data path, where the upstream clock drifts and the consumer can stall.

---
 rtl/manchester_rx_adaptive.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/manchester_rx_adaptive.sv
// Rate-tracking Manchester receiver: synchroniser, glitch filter, adaptive
// pulse-width classifier, bit decoder and MSB-first word assembler with valid/ready.
module manchester_rx_adaptive #(
  parameter int CNT_W           = 8,
  parameter int INIT_BIT_LENGTH = 24,
  parameter int WORD_W          = 8,
  parameter int FILTER          = 2,
  parameter int POLARITY        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              enable,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_locked,
  output logic              out_error,
  output logic              out_overrun,
  output logic [CNT_W-1:0]  out_pulsewidth
);

  localparam int XW  = CNT_W + 1;
  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  logic sync1, sync2, f, f_prev, edge_det;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  if (FILTER == 0) begin : g_bypass
    assign f = sync2;
  end else begin : g_filter
    localparam int FW = $clog2(FILTER + 1);
    logic [FW-1:0] run;
    logic          f_q;
    // f only follows sync2 after FILTER consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        run <= '0;
        f_q <= 1'b0;
      end else if (sync2 == f_q) begin
        run <= '0;
      end else if (run == FW'(FILTER - 1)) begin
        run <= '0;
        f_q <= sync2;
      end else begin
        run <= run + 1'b1;
      end
    end
    assign f = f_q;
  end

  assign edge_det = f ^ f_prev;

  logic [CNT_W-1:0]  cnt, len;
  logic [XW-1:0]     cnt_x, len_x, quarter_x, half_x, lo_long, hi_long;
  logic              is_long, is_short, is_invalid, timeout;
  logic [CNT_W+1:0]  adapt_sum;
  logic [CNT_W-1:0]  len_adapt;

  always_comb begin
    cnt_x      = {1'b0, cnt};
    len_x      = {1'b0, len};
    quarter_x  = {3'b000, len[CNT_W-1:2]};
    half_x     = {2'b00, len[CNT_W-1:1]};
    lo_long    = len_x - quarter_x;
    hi_long    = len_x + half_x;
    is_long    = edge_det && (cnt_x >= lo_long) && (cnt_x < hi_long);
    is_short   = edge_det && (cnt_x >= quarter_x) && (cnt_x < lo_long);
    is_invalid = edge_det && !is_long && !is_short;
    timeout    = !edge_det && (cnt_x >= hi_long);
    adapt_sum  = {2'b00, len} + {1'b0, len, 1'b0} + {2'b00, cnt};
    len_adapt  = adapt_sum[CNT_W+1:2];
    if (len_adapt < CNT_W'(4)) len_adapt = CNT_W'(4);
  end

  state_t state_q, state_d;
  logic   mid_q, mid_d, emit, lose, bit_val;

  assign bit_val = f_prev ^ (POLARITY != 0);

  // NOTE: defaults first so every path assigns every output; avoids inferred latches.
  always_comb begin
    state_d = state_q;
    mid_d   = mid_q;
    emit    = 1'b0;
    lose    = 1'b0;
    if (!enable) begin
      state_d = HUNT;
      mid_d   = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (is_long) begin
            state_d = LOCKED;
            mid_d   = 1'b1;
            emit    = 1'b1;
          end
        end
        LOCKED: begin
          if (is_long) begin
            emit  = 1'b1;
            mid_d = 1'b1;
          end else if (is_short) begin
            // A short edge after a mid-bit edge is the bit boundary and carries no data.
            emit  = !mid_q;
            mid_d = !mid_q;
          end else if (is_invalid || timeout) begin
            state_d = HUNT;
            mid_d   = 1'b0;
            lose    = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  logic [WORD_W-1:0] shreg, word_next;
  logic [BCW-1:0]    bit_cnt;

  assign word_next = {shreg[WORD_W-2:0], bit_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_prev      <= 1'b0;
      cnt         <= '0;
      len         <= CNT_W'(INIT_BIT_LENGTH);
      state_q     <= HUNT;
      mid_q       <= 1'b0;
      out_error   <= 1'b0;
      out_overrun <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      f_prev      <= f;
      state_q     <= state_d;
      mid_q       <= mid_d;
      out_error   <= lose;
      out_overrun <= 1'b0;

      if (!enable || edge_det) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + 1'b1;

      // The rate estimate survives loss of lock; only rst restores it.
      if (enable && is_long) len <= len_adapt;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (!enable || lose) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (emit) begin
        if (bit_cnt == BCW'(WORD_W - 1)) begin
          shreg   <= '0;
          bit_cnt <= '0;
          if (!out_valid || out_ready) begin
            out_data  <= word_next;
            out_valid <= 1'b1;
          end else begin
            out_overrun <= 1'b1;
          end
        end else begin
          shreg   <= word_next;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign out_locked     = (state_q == LOCKED);
  assign out_pulsewidth = len;

endmodule
